// File: rtl/bpu_pkg.sv
// bpu_pkg: opcodes, shadow-slot flag type and saturating-counter helpers
// shared by branch_predict_unit and its BTB.
package bpu_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Control bits of one shadow slot. The target, PHT index and GHR snapshot
    // travel beside it in arrays sized by the top's parameters.
    typedef struct packed {
        logic valid;
        logic taken;
        logic is_branch;
    } slot_flags_t;

    // Weakly not-taken: 2^(width-1)-1, returned zero-extended to 4 bits.
    function automatic logic [3:0] ctr_reset_val(input int unsigned width);
        return 4'((32'd1 << (width - 1)) - 32'd1);
    endfunction

    function automatic logic [3:0] ctr_inc(input logic [3:0] ctr, input int unsigned width);
        logic [3:0] max_v;
        max_v = 4'((32'd1 << width) - 32'd1);
        return (ctr == max_v) ? ctr : ctr + 4'd1;
    endfunction

    function automatic logic [3:0] ctr_dec(input logic [3:0] ctr);
        return (ctr == 4'd0) ? ctr : ctr - 4'd1;
    endfunction

endpackage

// File: rtl/bpu_btb.sv
// bpu_btb: direct-mapped branch target buffer. Combinational read, write at
// the clock edge, synchronous active-low clear of the valid bits.
module bpu_btb #(
    parameter int DATA_WIDTH = 32,
    parameter int BTB_DEPTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] rd_pc_i,
    output logic                  rd_hit_o,
    output logic [DATA_WIDTH-1:0] rd_target_o,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_pc_i,
    input  logic [DATA_WIDTH-1:0] wr_target_i
);
    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = DATA_WIDTH - IDX_W - 2;

    logic [BTB_DEPTH-1:0]  valid_q;
    logic [TAG_W-1:0]      tag_q    [BTB_DEPTH];
    logic [DATA_WIDTH-1:0] target_q [BTB_DEPTH];

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [TAG_W-1:0] wr_tag;
    logic             unused_bits;

    assign rd_idx      = rd_pc_i[IDX_W+1:2];
    assign rd_tag      = rd_pc_i[DATA_WIDTH-1:IDX_W+2];
    assign wr_idx      = wr_pc_i[IDX_W+1:2];
    assign wr_tag      = wr_pc_i[DATA_WIDTH-1:IDX_W+2];
    assign rd_hit_o    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign rd_target_o = target_q[rd_idx];
    assign unused_bits = ^{rd_pc_i[1:0], wr_pc_i[1:0]};

    // Valid bits: cleared by reset, set by a training write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and target payload; a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (rst && wr_en_i) begin
            tag_q[wr_idx]    <= wr_tag;
            target_q[wr_idx] <= wr_target_i;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: dynamic branch predictor with counter PHT, BTB and a
// shadow pipeline carrying each prediction to MEM for verdict and training.
// Optional feature: define BPU_GSHARE_EN to hash a global history register
// into the PHT index.
module branch_predict_unit
    import bpu_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int PHT_DEPTH      = 64,
    parameter int CTR_WIDTH      = 2,
    parameter int BTB_DEPTH      = 16,
    parameter int RESOLVE_STAGES = 3,
    parameter int GHR_WIDTH      = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold,
    input  logic                  stall,
    input  logic [DATA_WIDTH-1:0] pc_F,
    input  logic [DATA_WIDTH-1:0] instr_F,
    output logic                  prediction,
    output logic [DATA_WIDTH-1:0] label,
    input  logic                  res_valid,
    input  logic                  res_taken,
    input  logic [DATA_WIDTH-1:0] res_target,
    input  logic [DATA_WIDTH-1:0] res_pc,
    output logic                  correct,
    output logic                  error,
    output logic [DATA_WIDTH-1:0] new_label
);
    localparam int PHT_IDX_W = $clog2(PHT_DEPTH);
    localparam int LAST      = RESOLVE_STAGES - 1;
    localparam logic [CTR_WIDTH-1:0] CTR_RST = CTR_WIDTH'(ctr_reset_val(CTR_WIDTH));

    if (GHR_WIDTH < 2 || GHR_WIDTH > PHT_IDX_W || RESOLVE_STAGES < 2 ||
        CTR_WIDTH < 1 || CTR_WIDTH > 4 || PHT_DEPTH < 4) begin : g_param_check
        $error("branch_predict_unit: illegal parameter combination");
    end

    logic [CTR_WIDTH-1:0]  pht_q   [PHT_DEPTH];
    slot_flags_t           flags_q [RESOLVE_STAGES];
    logic [DATA_WIDTH-1:0] tgt_q   [RESOLVE_STAGES];
    logic [PHT_IDX_W-1:0]  idx_q   [RESOLVE_STAGES];
`ifdef BPU_GSHARE_EN
    logic [GHR_WIDTH-1:0]  ghr_q;
    logic [GHR_WIDTH-1:0]  snap_q  [RESOLVE_STAGES];
`endif

    logic                  is_br_f;
    logic                  is_jal_f;
    logic                  btb_hit_f;
    logic                  taken_f;
    logic [DATA_WIDTH-1:0] btb_tgt_f;
    logic [DATA_WIDTH-1:0] label_f;
    logic [PHT_IDX_W-1:0]  idx_f;
    slot_flags_t           capture_f;

    logic                  verdict_en;
    logic                  mispredict;
    logic                  train_ctr;
    logic                  btb_wr_en;
    logic [CTR_WIDTH-1:0]  ctr_d;
    logic                  unused_bits;

    assign unused_bits = ^instr_F[DATA_WIDTH-1:7];

    bpu_btb #(
        .DATA_WIDTH (DATA_WIDTH),
        .BTB_DEPTH  (BTB_DEPTH)
    ) u_btb (
        .clk         (clk),
        .rst         (rst),
        .rd_pc_i     (pc_F),
        .rd_hit_o    (btb_hit_f),
        .rd_target_o (btb_tgt_f),
        .wr_en_i     (btb_wr_en),
        .wr_pc_i     (res_pc),
        .wr_target_i (res_target)
    );

    // Fetch-side predecode and lookup against the pre-edge table contents.
    always_comb begin
        is_br_f  = (instr_F[6:0] == OP_BRANCH);
        is_jal_f = (instr_F[6:0] == OP_JAL);
`ifdef BPU_GSHARE_EN
        idx_f    = pc_F[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr_q);
`else
        idx_f    = pc_F[PHT_IDX_W+1:2];
`endif
        taken_f   = btb_hit_f & (is_jal_f | (is_br_f & pht_q[idx_f][CTR_WIDTH-1]));
        label_f   = taken_f ? btb_tgt_f : pc_F + DATA_WIDTH'(4);
        capture_f = '{valid: is_br_f | is_jal_f, taken: taken_f, is_branch: is_br_f};
    end

    assign prediction = taken_f;
    assign label      = label_f;

    // MEM verdict from the oldest slot, plus the counter's trained value.
    always_comb begin
        verdict_en = res_valid & flags_q[LAST].valid;
        mispredict = (flags_q[LAST].taken != res_taken) ||
                     (flags_q[LAST].taken && res_taken && (tgt_q[LAST] != res_target));
        train_ctr  = verdict_en & flags_q[LAST].is_branch;
        btb_wr_en  = res_valid & res_taken;
        ctr_d      = res_taken ? CTR_WIDTH'(ctr_inc(4'(pht_q[idx_q[LAST]]), CTR_WIDTH))
                               : CTR_WIDTH'(ctr_dec(4'(pht_q[idx_q[LAST]])));
    end

    assign error     = verdict_en & mispredict;
    assign correct   = verdict_en & ~mispredict;
    assign new_label = res_taken ? res_target : res_pc + DATA_WIDTH'(4);

    // Slot flags: a flush beats hold/stall; the MEM slot under hold keeps its
    // instruction, otherwise it would inherit a wrong-path entry and is cleared.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < RESOLVE_STAGES; i++) flags_q[i] <= '0;
        end else if (error) begin
            for (int i = 0; i < LAST; i++) flags_q[i] <= '0;
            if (!hold) flags_q[LAST] <= '0;
        end else if (!hold) begin
            for (int i = 2; i < RESOLVE_STAGES; i++) flags_q[i] <= flags_q[i-1];
            if (stall) begin
                flags_q[1] <= '0;
            end else begin
                flags_q[1] <= flags_q[0];
                flags_q[0] <= capture_f;
            end
        end
    end

    // Slot payload follows the same movement; contents of invalid slots are don't-care.
    always_ff @(posedge clk) begin
        if (!hold && !error) begin
            for (int i = 1; i < RESOLVE_STAGES; i++) begin
                tgt_q[i] <= tgt_q[i-1];
                idx_q[i] <= idx_q[i-1];
`ifdef BPU_GSHARE_EN
                snap_q[i] <= snap_q[i-1];
`endif
            end
            if (!stall) begin
                tgt_q[0] <= label_f;
                idx_q[0] <= idx_f;
`ifdef BPU_GSHARE_EN
                snap_q[0] <= ghr_q;
`endif
            end
        end
    end

    // Counter training at the index carried with the resolving branch.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < PHT_DEPTH; i++) pht_q[i] <= CTR_RST;
        end else if (train_ctr) begin
            pht_q[idx_q[LAST]] <= ctr_d;
        end
    end

`ifdef BPU_GSHARE_EN
    // Speculative history; repaired from the carried snapshot on a mispredict.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ghr_q <= '0;
        end else if (error) begin
            ghr_q <= {snap_q[LAST][GHR_WIDTH-2:0], res_taken};
        end else if (!hold && !stall && is_br_f) begin
            ghr_q <= {ghr_q[GHR_WIDTH-2:0], taken_f};
        end
    end
`endif

endmodule
